// File: rtl/snake_head_stepper.sv
// rtl/snake_head_stepper.sv - snake head motion stage: tick divider, direction handshake, bounded X/Y stepping
// Optional build macro: SNAKE_WRAP_AROUND_EN (wrap at playfield edges instead of dying)
module snake_head_stepper #(
    parameter int STEP     = 10,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int TICK_DIV = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    output logic [9:0] head_x,
    output logic [9:0] head_y,
    output logic [1:0] head_dir,
    output logic       moved,
    output logic       dead,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DEAD  = 2'b11;

    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int             CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  CNT_ZERO  = '0;
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] XMAX_W  = 11'(X_MAX);
    localparam logic [10:0] YMAX_W  = 11'(Y_MAX);
    localparam logic [9:0]  XINIT_W = 10'(X_INIT);
    localparam logic [9:0]  YINIT_W = 10'(Y_INIT);

    logic [1:0]    state_next;
    logic [CW-1:0] tick_cnt;
    logic [1:0]    pend_dir;
    logic          tick;
    logic          kill;

    logic          use_x;
    logic          sub_op;
    logic [10:0]   coord;
    logic [10:0]   coord_max;
    logic [10:0]   coord_res;
    logic          violation;
    logic          step_ok;

    logic [1:0]    ref_dir;
    logic          dir_accept;

    assign tick = (state == ST_RUN) && (tick_cnt == TICK_LAST);

    // Step arithmetic: pending direction picks axis and add/sub; 11-bit compare keeps the carry-out
    always_comb begin
        use_x     = pend_dir[1];
        sub_op    = ~pend_dir[0];
        coord     = use_x ? {1'b0, head_x} : {1'b0, head_y};
        coord_max = use_x ? XMAX_W : YMAX_W;
        violation = 1'b0;
        if (sub_op) begin
            violation = (coord < STEP_W);
            coord_res = coord - STEP_W;
`ifdef SNAKE_WRAP_AROUND_EN
            if (violation) begin
                coord_res = coord_max - (STEP_W - 11'd1 - coord);
            end
`endif
        end else begin
            coord_res = coord + STEP_W;
            violation = (coord_res > coord_max);
`ifdef SNAKE_WRAP_AROUND_EN
            if (violation) begin
                coord_res = coord_res - (coord_max + 11'd1);
            end
`endif
        end
`ifdef SNAKE_WRAP_AROUND_EN
        step_ok = 1'b1;
        kill    = 1'b0;
`else
        step_ok = ~violation;
        kill    = tick & violation;
`endif
    end

    // Direction filter: on a tick cycle the reverse check uses the direction being committed now
    always_comb begin
        ref_dir    = tick ? pend_dir : head_dir;
        dir_accept = dir_valid
                     && ((state == ST_RUN) || (state == ST_PAUSE))
                     && (dir_req != (ref_dir ^ 2'b01));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; a tick outranks pause in the same cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (kill) begin
                    state_next = ST_DEAD;
                end else if (pause) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: if (!pause) state_next = ST_RUN;
            ST_DEAD:  if (start) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath: counter, pending/committed direction, coordinates, pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            head_x   <= XINIT_W;
            head_y   <= YINIT_W;
            head_dir <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            moved    <= 1'b0;
            dead     <= 1'b0;
            tick_cnt <= CNT_ZERO;
        end else begin
            moved <= 1'b0;
            dead  <= (state_next == ST_DEAD);

            if (state == ST_RUN) begin
                if (tick) begin
                    tick_cnt <= CNT_ZERO;
                end else if (!pause) begin
                    tick_cnt <= tick_cnt + CNT_ONE;
                end
            end else if (state != ST_PAUSE) begin
                tick_cnt <= CNT_ZERO;
            end

            if (tick) begin
                head_dir <= pend_dir;
                if (step_ok) begin
                    if (use_x) begin
                        head_x <= coord_res[9:0];
                    end else begin
                        head_y <= coord_res[9:0];
                    end
                    moved <= 1'b1;
                end
            end

            if (dir_accept) begin
                pend_dir <= dir_req;
            end

            if ((state == ST_DEAD) && start) begin
                head_x   <= XINIT_W;
                head_y   <= YINIT_W;
                head_dir <= DIR_RIGHT;
                pend_dir <= DIR_RIGHT;
            end
        end
    end

endmodule

// File: tb/tb_snake_head_stepper.sv
// tb/tb_snake_head_stepper.sv - directed self-checking bench for snake_head_stepper
module tb_snake_head_stepper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic       dir_valid;
    logic [1:0] dir_req;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic [1:0] head_dir;
    logic       moved;
    logic       dead;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    snake_head_stepper #(
        .STEP     (10),
        .X_MAX    (639),
        .Y_MAX    (479),
        .X_INIT   (320),
        .Y_INIT   (240),
        .TICK_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .dir_valid (dir_valid),
        .dir_req   (dir_req),
        .head_x    (head_x),
        .head_y    (head_y),
        .head_dir  (head_dir),
        .moved     (moved),
        .dead      (dead),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_x"},     32'(head_x), 32'd320);
        check({tag, "_y"},     32'(head_y), 32'd240);
        check({tag, "_dir"},   32'(head_dir), 32'd3);
        check({tag, "_moved"}, 32'(moved), 32'd0);
        check({tag, "_dead"},  32'(dead), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; dir_valid = 1'b0; dir_req = 2'b00;
        cyc(); cyc();
        rst = 1'b0;
        check_reset_values("reset");

        // start, first step TICK_DIV cycles later
        start = 1'b1; cyc(); start = 1'b0;
        check("start_run", 32'(state), 32'd1);
        cyc(); cyc(); cyc();
        check("pre_step_x", 32'(head_x), 32'd320);
        check("pre_step_moved", 32'(moved), 32'd0);
        cyc();
        check("step1_x", 32'(head_x), 32'd330);
        check("step1_y", 32'(head_y), 32'd240);
        check("step1_moved", 32'(moved), 32'd1);
        cyc();
        check("step1_moved_drop", 32'(moved), 32'd0);

        // reverse request (left while heading right) is dropped
        dir_valid = 1'b1; dir_req = 2'b10; cyc(); dir_valid = 1'b0;
        cyc(); cyc();
        check("rev_x", 32'(head_x), 32'd340);
        check("rev_dir", 32'(head_dir), 32'd3);

        // up then down before one tick: last accepted wins
        dir_valid = 1'b1; dir_req = 2'b00; cyc();
        dir_req = 2'b01; cyc(); dir_valid = 1'b0;
        cyc(); cyc();
        check("last_wins_y", 32'(head_y), 32'd250);
        check("last_wins_dir", 32'(head_dir), 32'd1);
        check("last_wins_x", 32'(head_x), 32'd340);

        // pause at counter=2 for 10 cycles, start ignored while paused
        cyc(); cyc();
        pause = 1'b1; cyc();
        check("pause_state", 32'(state), 32'd2);
        repeat (4) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        check("pause_start_ignored", 32'(state), 32'd2);
        repeat (4) cyc();
        check("pause_hold_y", 32'(head_y), 32'd250);
        check("pause_moved", 32'(moved), 32'd0);
        pause = 1'b0; cyc();
        check("resume_state", 32'(state), 32'd1);
        cyc();
        check("resume_early_y", 32'(head_y), 32'd250);
        check("resume_early_moved", 32'(moved), 32'd0);
        cyc();
        check("resume_step_y", 32'(head_y), 32'd260);
        check("resume_step_moved", 32'(moved), 32'd1);

        // pause on the tick cycle: step happens, then PAUSE
        cyc(); cyc(); cyc();
        pause = 1'b1; cyc();
        check("tick_pause_y", 32'(head_y), 32'd270);
        check("tick_pause_moved", 32'(moved), 32'd1);
        check("tick_pause_state", 32'(state), 32'd2);

        // turn left while paused, then run to the left edge
        pause = 1'b0; dir_valid = 1'b1; dir_req = 2'b10; cyc(); dir_valid = 1'b0;
        check("left_resume_state", 32'(state), 32'd1);
        check("left_pending_dir", 32'(head_dir), 32'd1);
        for (int k = 1; k <= 34; k++) begin
            repeat (4) cyc();
            check("left_walk_x", 32'(head_x), 32'(340 - 10 * k));
            check("left_walk_moved", 32'(moved), 32'd1);
        end
        check("left_edge_dir", 32'(head_dir), 32'd2);
        check("left_edge_state", 32'(state), 32'd1);
        repeat (4) cyc();
`ifdef SNAKE_WRAP_AROUND_EN
        check("wrap_left_x", 32'(head_x), 32'd630);
        check("wrap_left_moved", 32'(moved), 32'd1);
        check("wrap_left_dead", 32'(dead), 32'd0);
        check("wrap_left_state", 32'(state), 32'd1);
`else
        check("die_left_state", 32'(state), 32'd3);
        check("die_left_dead", 32'(dead), 32'd1);
        check("die_left_x", 32'(head_x), 32'd0);
        check("die_left_moved", 32'(moved), 32'd0);
        dir_valid = 1'b1; dir_req = 2'b00; cyc(); dir_valid = 1'b0;
        check("dead_dir_ignored", 32'(head_dir), 32'd2);
        check("dead_moved", 32'(moved), 32'd0);
        check("dead_stays", 32'(state), 32'd3);
        start = 1'b1; cyc(); start = 1'b0;
        check_reset_values("restart");
`endif

        // start (ignored if already running), then reset mid-RUN
        start = 1'b1; cyc(); start = 1'b0;
        check("run_again_state", 32'(state), 32'd1);
        cyc(); cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        check_reset_values("mid_run_reset");

        // run right to the far edge
        start = 1'b1; cyc(); start = 1'b0;
        check("right_run_state", 32'(state), 32'd1);
        for (int k = 1; k <= 31; k++) begin
            repeat (4) cyc();
            check("right_walk_x", 32'(head_x), 32'(320 + 10 * k));
        end
        repeat (4) cyc();
`ifdef SNAKE_WRAP_AROUND_EN
        check("wrap_right_x", 32'(head_x), 32'd0);
        check("wrap_right_moved", 32'(moved), 32'd1);
        check("wrap_right_state", 32'(state), 32'd1);
`else
        check("die_right_x", 32'(head_x), 32'd630);
        check("die_right_state", 32'(state), 32'd3);
        check("die_right_dead", 32'(dead), 32'd1);
        check("die_right_moved", 32'(moved), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
